result_ram_acc: RTL
===================

RESULT_RAM_ACC -- requirements
Module: result_ram_acc

Interface
REQ-001 SHALL have parameter DW, default 19, meaning signed data width.
REQ-002 SHALL have parameter AW, default 6, meaning address width; depth = 2**AW words.
REQ-003 SHALL have parameter SAT, default 1, meaning 1 = saturating accumulate, 0 = wrapping accumulate.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port addr, input, AW bits: read/write/accumulate address.
REQ-007 SHALL have port mdi, input, DW bits, signed: write or accumulate operand.
REQ-008 SHALL have port mwr, input, 1 bit: write strobe.
REQ-009 SHALL have port macc, input, 1 bit: with mwr=1, selects accumulate (mem += mdi) instead of overwrite.
REQ-010 SHALL have port clr_start, input, 1 bit: single-cycle request to zero the whole memory.
REQ-011 SHALL have port data_out, output reg, DW bits, signed: registered read data.
REQ-012 SHALL have port busy, output, 1 bit: high while a clear sweep runs.
REQ-013 SHALL have port clr_done, output reg, 1 bit: one-cycle pulse when a clear sweep completes.

Function
REQ-014 Each cycle with busy=0, data_out SHALL load the contents of addr, giving 1-cycle read latency, with read-before-write for a plain write to the same address.
REQ-015 mwr=1, macc=0, busy=0 SHALL write mdi to mem[addr] at that edge.
REQ-016 mwr=1, macc=1, busy=0 SHALL run a 2-stage read-modify-write: stage 1 reads mem[addr] and registers addr/mdi; stage 2 writes old+mdi on the next edge.
REQ-017 An accumulate SHALL sustain one op per cycle, including back-to-back ops to the same address.
REQ-018 When stage 1 reads the address stage 2 is writing, stage 2's sum SHALL be forwarded so no update is lost; the same forwarding SHALL apply to data_out.
REQ-019 The accumulate sum SHALL be computed at DW+1 bits.
REQ-020 With SAT=1, the sum SHALL clamp to +(2**(DW-1)-1) or -(2**(DW-1)); with SAT=0 it SHALL truncate to DW bits (two's-complement wrap).
REQ-021 A plain write to the address currently in stage 2 SHALL take priority over the pending accumulate result, so the last-issued op wins.
REQ-022 The FSM SHALL have states IDLE and CLEAR.
REQ-023 IDLE -> CLEAR SHALL occur on clr_start=1, with a pending stage-2 accumulate allowed to complete first on the same edge.
REQ-024 CLEAR SHALL write 0 to addresses 0 .. 2**AW-1 in ascending order, one per cycle, taking 2**AW cycles.
REQ-025 After the final address, CLEAR -> IDLE SHALL occur with clr_done=1 for exactly one cycle.
REQ-026 busy SHALL equal (state == CLEAR).
REQ-027 While busy=1, mwr, macc, and clr_start SHALL be ignored and data_out SHALL hold its value.
REQ-028 clr_start asserted while already in CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-029 The address counter SHALL NOT wrap past 2**AW-1 into a second sweep.

Reset
REQ-030 rst=1 SHALL force data_out=0, busy=0, clr_done=0, state=IDLE, clear counter=0, and stage-2 valid=0 at the next edge.
REQ-031 Memory contents SHALL NOT be reset by rst.
REQ-032 rst during CLEAR SHALL abort the sweep, leaving addresses not yet swept unchanged, with no clr_done pulse.
REQ-033 rst with a stage-2 accumulate pending SHALL discard that write.
REQ-034 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Plain write then read: write 100 to addr 5, next cycle read addr 5 -> data_out=100 one cycle later; a same-cycle write+read of addr 5 returns the old value.
REQ-036 Back-to-back accumulate: mem[3]=10, then accumulate +5, +7, -2 to addr 3 on consecutive cycles -> mem[3]=20, read returns 20.
REQ-037 Saturation with SAT=1, DW=19: mem[0]=262140, accumulate +10 -> 262143; mem[1]=-262140, accumulate -10 -> -262144.
REQ-038 Wrap with SAT=0: mem[0]=262143, accumulate +1 -> -262144.
REQ-039 Clear sweep: all addresses nonzero, pulse clr_start -> busy high 64 cycles, clr_done pulses once, all 64 reads return 0, and mwr during busy has no effect.
REQ-040 Reset mid-clear: assert rst 20 cycles into a sweep -> busy=0 next cycle, addresses 0..19 read 0, addresses 20..63 keep their prior values, no clr_done pulse.

Source files
------------

// File: rtl/result_ram_acc.sv
// Result RAM with plain write, pipelined read-modify-write accumulate
// (forwarded, optionally saturating) and a whole-memory clear sweep.
module result_ram_acc #(
    parameter int DW  = 19,
    parameter int AW  = 6,
    parameter int SAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        addr,
    input  logic signed [DW-1:0] mdi,
    input  logic                 mwr,
    input  logic                 macc,
    input  logic                 clr_start,
    output logic signed [DW-1:0] data_out,
    output logic                 busy,
    output logic                 clr_done
);

    localparam int DEPTH = 1 << AW;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [AW-1:0]        LAST_ADDR = {AW{1'b1}};
    localparam logic signed [DW-1:0] MAX_V     = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MIN_V     = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW-1:0] r_mem [DEPTH];

    logic [0:0]           r_state;
    logic [AW-1:0]        r_clr_cnt;
    logic                 r_s2_valid;
    logic [AW-1:0]        r_s2_addr;
    logic signed [DW-1:0] r_s2_old;
    logic signed [DW-1:0] r_s2_mdi;

    logic                 w_idle;
    logic                 w_plain_wr;
    logic                 w_acc_issue;
    logic                 w_s2_hit;
    logic [DW:0]          w_sum_wide;
    logic signed [DW-1:0] w_s2_sum;
    logic signed [DW-1:0] w_rd_fwd;

    assign w_idle     = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_CLEAR);
    assign w_plain_wr = w_idle & mwr & ~macc;
    // An accumulate issued alongside clr_start is dropped: its stage-2 write
    // would otherwise land in the middle of the sweep.
    assign w_acc_issue = w_idle & mwr & macc & ~clr_start;
    assign w_s2_hit    = r_s2_valid && (r_s2_addr == addr);

    assign w_sum_wide = {r_s2_old[DW-1], r_s2_old} + {r_s2_mdi[DW-1], r_s2_mdi};

    always_comb begin
        w_s2_sum = w_sum_wide[DW-1:0];
        if (SAT != 0 && (w_sum_wide[DW] != w_sum_wide[DW-1])) begin
            w_s2_sum = w_sum_wide[DW] ? MIN_V : MAX_V;
        end
    end

    // Read view of addr including the stage-2 result not yet in the array.
    assign w_rd_fwd = w_s2_hit ? w_s2_sum : r_mem[addr];

    // Plain write is applied after the stage-2 write so it wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                if (r_s2_valid) begin
                    r_mem[r_s2_addr] <= w_s2_sum;
                end
                if (w_plain_wr) begin
                    r_mem[addr] <= mdi;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_s2_valid <= 1'b0;
            data_out   <= '0;
            clr_done   <= 1'b0;
        end else begin
            clr_done   <= 1'b0;
            r_s2_valid <= w_acc_issue;
            if (w_acc_issue) begin
                r_s2_addr <= addr;
                r_s2_mdi  <= mdi;
                r_s2_old  <= w_rd_fwd;
            end
            if (w_idle) begin
                data_out <= w_rd_fwd;
            end
            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                        clr_done  <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
